serial_tx_arbiter: RTL and testbench

Shares the single serial output line between two frame sources (audio path = requester 0, keyboard/mouse reply path = requester 1). It grants one requester at a time with round-robin priority and serializes its 40-bit frame. The line format is a start bit (1), then 40 data bits MSB first, then a fixed idle gap (0). This is the exact format the block's existing serial receiver decodes.

---
 rtl/serial_tx_arbiter_if.sv | 22 ++
 rtl/serial_tx_arbiter.sv | 115 +++++++++++
 tb/tb_serial_tx_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_tx_arbiter_if.sv
// Request bundle for the two frame sources feeding serial_tx_arbiter.
// Sources own valid/data; the arbiter returns a one-cycle ready on accept.
interface serial_tx_arbiter_if #(
    parameter int FRAME_BITS = 40
);
    logic                  req0_valid;
    logic [FRAME_BITS-1:0] req0_data;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [FRAME_BITS-1:0] req1_data;
    logic                  req1_ready;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Round-robin two-source serial framer: start bit, FRAME_BITS data bits MSB first, GAP_CYCLES idle.
// Start bit one cycle after accept; ready only in IDLE, so requests made mid-frame wait their turn.
module serial_tx_arbiter #(
    parameter int FRAME_BITS = 40,
    parameter int GAP_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    serial_tx_arbiter_if.slave  req,
    output logic                so,
    output logic                busy,
    output logic                grant_id,
    output logic                frame_done
);
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(FRAME_BITS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, SHIFT, GAP} state_t;

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
    logic                  so_q, so_d;
    logic                  frame_done_q, frame_done_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic                  win1;
    logic                  idle_ok;

    // Requester 1 wins when alone, or when both ask and requester 0 went last.
    assign win1    = req.req1_valid & (~req.req0_valid | ~last_grant_q);
    assign idle_ok = ~rst & (state_q == IDLE);

    assign req.req0_ready = idle_ok & req.req0_valid & ~win1;
    assign req.req1_ready = idle_ok & win1;

    assign so         = so_q;
    assign busy       = (state_q != IDLE);
    assign grant_id   = grant_q;
    assign frame_done = frame_done_q;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        so_d         = 1'b0;
        frame_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req.req0_valid | req.req1_valid) begin
                    state_d      = START;
                    so_d         = 1'b1;
                    shreg_d      = win1 ? req.req1_data : req.req0_data;
                    grant_d      = win1;
                    last_grant_d = win1;
                end
            end
            START: begin
                state_d   = SHIFT;
                bit_cnt_d = '0;
                so_d      = shreg_q[FRAME_BITS-1];
                shreg_d   = shreg_q << 1;
            end
            SHIFT: begin
                // so is registered, so the bit for the next cycle is chosen here.
                if (bit_cnt_q == BIT_LAST) begin
                    state_d      = GAP;
                    gap_cnt_d    = '0;
                    frame_done_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    so_d      = shreg_q[FRAME_BITS-1];
                    shreg_d   = shreg_q << 1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            so_q         <= 1'b0;
            frame_done_q <= 1'b0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            so_q         <= so_d;
            frame_done_q <= frame_done_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: frame vector table plus hand-written corner sequences.
module tb_serial_tx_arbiter;
    localparam int FB = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_tx_arbiter_if #(.FRAME_BITS(FB)) bus ();
    serial_tx_arbiter_if #(.FRAME_BITS(FB)) bus_g1 ();

    logic so, busy, grant_id, frame_done;
    logic so_g1, busy_g1, grant_id_g1, frame_done_g1;

    serial_tx_arbiter #(.FRAME_BITS(FB), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(bus.slave),
        .so(so), .busy(busy), .grant_id(grant_id), .frame_done(frame_done)
    );

    serial_tx_arbiter #(.FRAME_BITS(FB), .GAP_CYCLES(1)) dut_g1 (
        .clk(clk), .rst(rst), .req(bus_g1.slave),
        .so(so_g1), .busy(busy_g1), .grant_id(grant_id_g1), .frame_done(frame_done_g1)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference receiver: start bit, 40 bits MSB first, then one idle 0 completes the frame.
    typedef enum logic [1:0] {R_IDLE, R_DATA, R_END} rx_state_t;
    rx_state_t   rx_state;
    logic [39:0] rx_shreg;
    logic [39:0] rx_data;
    logic        data_recv;
    int          rx_cnt;
    logic [39:0] rx_q[$];

    always @(posedge clk) begin
        data_recv <= 1'b0;
        if (rst) begin
            rx_state <= R_IDLE;
            rx_cnt   <= 0;
        end else begin
            case (rx_state)
                R_IDLE: if (so_g1) begin rx_state <= R_DATA; rx_cnt <= 0; end
                R_DATA: begin
                    rx_shreg <= {rx_shreg[38:0], so_g1};
                    if (rx_cnt == 39) rx_state <= R_END;
                    else rx_cnt <= rx_cnt + 1;
                end
                default: begin
                    if (!so_g1) begin
                        data_recv <= 1'b1;
                        rx_data   <= rx_shreg;
                    end
                    rx_state <= R_IDLE;
                end
            endcase
        end
    end

    always @(posedge clk) if (data_recv) rx_q.push_back(rx_data);

    typedef struct {
        logic        v0;
        logic        v1;
        logic [39:0] d0;
        logic [39:0] d1;
        logic        exp_id;
        logic [39:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic clear_valids();
        bus.req0_valid    = 1'b0;
        bus.req1_valid    = 1'b0;
        bus_g1.req0_valid = 1'b0;
        bus_g1.req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_valids();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one vector, wait for its accept, then follow the whole frame on the line.
    task automatic run_frame(input int idx, input vec_t v);
        int n;
        logic [39:0] got;
        bus.req0_valid = v.v0;
        bus.req1_valid = v.v1;
        bus.req0_data  = v.d0;
        bus.req1_data  = v.d1;
        #1;
        n = 0;
        while (!(bus.req0_ready | bus.req1_ready) && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check($sformatf("v%0d_accept", idx), 64'(n < 100), 64'd1);
        if (n >= 100) return;
        check($sformatf("v%0d_one_ready", idx), 64'(bus.req0_ready & bus.req1_ready), 64'd0);
        check($sformatf("v%0d_ready_id", idx), 64'(bus.req1_ready), 64'(v.exp_id));
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check($sformatf("v%0d_start_bit", idx), 64'(so), 64'd1);
        check($sformatf("v%0d_busy_start", idx), 64'(busy), 64'd1);
        got = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            got[39-i] = so;
        end
        check($sformatf("v%0d_data", idx), 64'(got), 64'(v.exp_data));
        @(negedge clk);
        check($sformatf("v%0d_done", idx), 64'(frame_done), 64'd1);
        check($sformatf("v%0d_gap_so", idx), 64'(so), 64'd0);
        check($sformatf("v%0d_grant_id", idx), 64'(grant_id), 64'(v.exp_id));
        @(negedge clk);
        check($sformatf("v%0d_done_once", idx), 64'(frame_done), 64'd0);
        check($sformatf("v%0d_busy_gap", idx), 64'(busy), 64'd1);
        @(negedge clk);
        check($sformatf("v%0d_idle_busy", idx), 64'(busy), 64'd0);
        check($sformatf("v%0d_idle_so", idx), 64'(so), 64'd0);
    endtask

    int  acc_cyc[$];
    logic acc_id[$];
    logic both_seen;
    int  n;

    initial begin
        // Round-robin history starts with requester 1 as last grant, so 0 wins first.
        vecs[0] = '{1'b1, 1'b0, 40'hA9F0AAAAA9, 40'h0,          1'b0, 40'hA9F0AAAAA9};
        vecs[1] = '{1'b1, 1'b1, 40'h1,          40'h2,          1'b1, 40'h2};
        vecs[2] = '{1'b1, 1'b1, 40'h1,          40'h2,          1'b0, 40'h1};
        vecs[3] = '{1'b1, 1'b1, 40'h1,          40'h2,          1'b1, 40'h2};
        vecs[4] = '{1'b0, 1'b1, 40'h0,          40'h123456789A, 1'b1, 40'h123456789A};
        vecs[5] = '{1'b0, 1'b1, 40'h0,          40'hFFFF00FF00, 1'b1, 40'hFFFF00FF00};
        vecs[6] = '{1'b1, 1'b0, 40'h8000000001, 40'h0,          1'b0, 40'h8000000001};
        vecs[7] = '{1'b1, 1'b1, 40'hCAFEBABE55, 40'h0F0F0F0F0F, 1'b1, 40'h0F0F0F0F0F};

        rst = 1'b1;
        bus.req0_data = '0; bus.req1_data = '0;
        bus_g1.req0_data = '0; bus_g1.req1_data = '0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus_g1.req0_valid = 1'b0;
        bus_g1.req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check("rst_ready0", 64'(bus.req0_ready), 64'd0);
        check("rst_ready1", 64'(bus.req1_ready), 64'd0);
        check("rst_so", 64'(so), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        check("rst_grant", 64'(grant_id), 64'd0);
        clear_valids();
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_frame(i, vecs[i]);

        // Both requesters held continuously: alternating grants, 44 cycles apart.
        do_reset();
        bus.req0_data = 40'h1; bus.req1_data = 40'h2;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        both_seen = 1'b0;
        for (int c = 0; c < 150; c++) begin
            logic took;
            took = 1'b0;
            if (acc_cyc.size() >= 4) break;
            if (bus.req0_ready & bus.req1_ready) both_seen = 1'b1;
            if (bus.req0_ready | bus.req1_ready) begin
                acc_cyc.push_back(c);
                acc_id.push_back(bus.req1_ready);
                took = 1'b1;
            end
            @(negedge clk); #1;
            if (took) check($sformatf("rr_grant_id%0d", acc_cyc.size()), 64'(grant_id), 64'(acc_id[$]));
        end
        check("rr_accepts", 64'(acc_cyc.size()), 64'd4);
        check("rr_both_ready", 64'(both_seen), 64'd0);
        if (acc_cyc.size() == 4) begin
            for (int k = 0; k < 4; k++)
                check($sformatf("rr_order%0d", k), 64'(acc_id[k]), 64'(k % 2));
            for (int k = 1; k < 4; k++)
                check($sformatf("rr_spacing%0d", k), 64'(acc_cyc[k] - acc_cyc[k-1]), 64'd44);
        end

        // Late arrival: requester 1 shows up mid-frame and waits for IDLE.
        do_reset();
        bus.req0_data = 40'h55AA55AA55; bus.req0_valid = 1'b1;
        #1;
        check("late_first_ready0", 64'(bus.req0_ready), 64'd1);
        for (int c = 1; c <= 43; c++) begin
            @(negedge clk);
            if (c == 10) begin
                bus.req1_data  = 40'h3C3C3C3C3C;
                bus.req1_valid = 1'b1;
            end
            #1;
            check($sformatf("late_no_ready_c%0d", c), 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
        end
        @(negedge clk); #1;
        check("late_ready1", 64'(bus.req1_ready), 64'd1);
        check("late_ready0", 64'(bus.req0_ready), 64'd0);

        // Reset during data bit 10 abandons the frame and restores requester 0 priority.
        do_reset();
        bus.req0_data = 40'hF0F0F0F0F0; bus.req0_valid = 1'b1;
        #1;
        check("mid_first_ready0", 64'(bus.req0_ready), 64'd1);
        for (int c = 1; c <= 11; c++) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.req1_data  = 40'h0000000002;
        bus.req1_valid = 1'b1;
        #1;
        check("mid_rst_no_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
        @(negedge clk); #1;
        check("mid_so", 64'(so), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_done", 64'(frame_done), 64'd0);
        rst = 1'b0;
        #1;
        check("mid_after_ready0", 64'(bus.req0_ready), 64'd1);
        check("mid_after_ready1", 64'(bus.req1_ready), 64'd0);
        @(negedge clk); #1;
        check("mid_after_done", 64'(frame_done), 64'd0);
        check("mid_after_start", 64'(so), 64'd1);

        // Loopback with a single-cycle gap: two back-to-back frames into the receiver.
        do_reset();
        rx_q.delete();
        acc_cyc.delete();
        acc_id.delete();
        bus_g1.req0_data = 40'h123456789A; bus_g1.req1_data = 40'h0F1E2D3C4B;
        bus_g1.req0_valid = 1'b1; bus_g1.req1_valid = 1'b1;
        #1;
        n = 0;
        while (rx_q.size() < 2 && n < 300) begin
            if (acc_cyc.size() < 2 && (bus_g1.req0_ready | bus_g1.req1_ready)) begin
                acc_cyc.push_back(n);
                acc_id.push_back(bus_g1.req1_ready);
            end
            @(negedge clk);
            if (acc_cyc.size() >= 2) begin
                bus_g1.req0_valid = 1'b0;
                bus_g1.req1_valid = 1'b0;
            end
            #1;
            n++;
        end
        check("lb_timeout", 64'(n < 300), 64'd1);
        check("lb_frames", 64'(rx_q.size()), 64'd2);
        if (rx_q.size() >= 2) begin
            check("lb_frame0", 64'(rx_q[0]), 64'h123456789A);
            check("lb_frame1", 64'(rx_q[1]), 64'h0F1E2D3C4B);
        end
        if (acc_cyc.size() == 2) begin
            check("lb_id0", 64'(acc_id[0]), 64'd0);
            check("lb_id1", 64'(acc_id[1]), 64'd1);
            check("lb_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd43);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
